// File: rtl/alu_result_bcd.sv
// alu_result_bcd
// Downstream stage of the 8-bit pin ALU. Takes the ALU output byte
// {op[1:0], result[RES_W-1:0]}, converts the result field to packed BCD with a
// sequential shift-add-3 (double-dabble) engine and passes the opcode through.
//
// Optional build macro: SIGNED_EN
//   When defined, a subtract result (op == 2'b01) with its MSB set is treated
//   as two's complement: sign_out = 1 and the magnitude is converted. When not
//   defined, sign_out is always 0 and every op converts unsigned.
//
// Handshakes (both sides): a transfer happens on a rising CLK edge where
// valid and ready are both high. The producer holds data stable from raising
// valid until that edge; the consumer may hold ready low indefinitely.
//
// Ports:
//   CLK        clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    ALU output byte {op, result}
//   in_valid   in_data valid
//   in_ready   block can accept (high only in IDLE)
//   bcd_out    packed BCD, most-significant digit in the top nibble
//   op_out     opcode captured with the result
//   sign_out   negative flag (SIGNED_EN builds only, else 0)
//   out_valid  bcd_out/op_out/sign_out valid
//   out_ready  downstream consumes the result
//   busy       conversion in progress
//
// The FSM state is held in the signal 'state' (type state_t) for probing.

module alu_result_bcd #(
    parameter int RES_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [RES_W+1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [1:0]            op_out,
    output logic                  sign_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int CNT_W = $clog2(RES_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(RES_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [RES_W-1:0]    shreg;
    logic [4*DIGITS-1:0] bcd_acc;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_shifted;
    logic [CNT_W-1:0]    cnt;
    logic                sign_reg;

    logic [RES_W-1:0]    field;
    logic [1:0]          op_in;
    logic                accept;
    logic                last_iter;

    assign field     = in_data[RES_W-1:0];
    assign op_in     = in_data[RES_W+1:RES_W];
    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (state == CONV) && (cnt == LAST_ITER);

    // State register
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = CONV;
            CONV:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: handshake flags decode directly from the state
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CONV:    busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Add-3 correction: every nibble >= 5 gets +3 before the shift, so that
    // after doubling it carries correctly into the next decimal digit.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // Shift {bcd, shreg} left by one: the MSB of shreg enters the BCD LSB.
    assign bcd_shifted = {bcd_adj[4*DIGITS-2:0], shreg[RES_W-1]};

    // Datapath
    always_ff @(posedge CLK) begin
        if (rst) begin
            shreg    <= '0;
            bcd_acc  <= '0;
            cnt      <= '0;
            bcd_out  <= '0;
            op_out   <= '0;
            sign_reg <= 1'b0;
        end else if (accept) begin
            bcd_acc <= '0;
            cnt     <= '0;
            op_out  <= op_in;
`ifdef SIGNED_EN
            // Negate at capture so conversion latency is the same for both signs.
            if (op_in == 2'b01 && field[RES_W-1]) begin
                shreg    <= (~field) + RES_W'(1);
                sign_reg <= 1'b1;
            end else begin
                shreg    <= field;
                sign_reg <= 1'b0;
            end
`else
            shreg    <= field;
            sign_reg <= 1'b0;
`endif
        end else if (state == CONV) begin
            bcd_acc <= bcd_shifted;
            shreg   <= {shreg[RES_W-2:0], 1'b0};
            cnt     <= cnt + CNT_W'(1);
            // The last shift publishes the finished value together with DONE.
            if (last_iter) begin
                bcd_out <= bcd_shifted;
            end
        end
    end

    assign sign_out = sign_reg;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed testbench for alu_result_bcd (default parameters RES_W=6, DIGITS=2).

module tb_alu_result_bcd;

    logic       CLK;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bcd_out;
    logic [1:0] op_out;
    logic       sign_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int compared;
    int mismatched;

    alu_result_bcd dut (
        .CLK       (CLK),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .op_out    (op_out),
        .sign_out  (sign_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present d while in_ready is high; returns after the acceptance edge.
    task automatic accept(input logic [7:0] d);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen (bounded); lat = edges after acceptance.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        compared++;
        if (bcd_out !== 8'h00) begin mismatched++; $display("FAIL reset_bcd got=%h exp=00", bcd_out); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
        compared++;
        if (op_out !== 2'b00 || sign_out !== 1'b0) begin
            mismatched++; $display("FAIL reset_op_sign got=%b/%b exp=00/0", op_out, sign_out);
        end
    endtask

    task automatic test_max_value();
        int lat;
        out_ready = 1'b1;
        accept(8'b00_111111);
        compared++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            mismatched++; $display("FAIL max_busy busy=%b in_ready=%b exp=1/0", busy, in_ready);
        end
        wait_out(lat);
        compared++;
        if (lat !== 6) begin mismatched++; $display("FAIL max_latency got=%0d exp=6", lat); end
        compared++;
        if (bcd_out !== 8'h63) begin mismatched++; $display("FAIL max_bcd got=%h exp=63", bcd_out); end
        compared++;
        if (op_out !== 2'b00 || busy !== 1'b0) begin
            mismatched++; $display("FAIL max_op_busy op=%b busy=%b exp=00/0", op_out, busy);
        end
        tick();
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++; $display("FAIL max_pulse out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        accept(8'b10_101010);
        wait_out(lat);
        compared++;
        if (lat !== 6) begin mismatched++; $display("FAIL bp_latency got=%0d exp=6", lat); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 8'b01_000111;
            tick();
            if (out_valid !== 1'b1 || bcd_out !== 8'h42 || op_out !== 2'b10 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL bp_hold bad_cycles=%0d exp=0 (last bcd=%h op=%b valid=%b)", bad, bcd_out, op_out, out_valid);
        end
        out_ready = 1'b1;
        tick();
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++; $display("FAIL bp_release out_valid=%b in_ready=%b exp=0/1", out_valid, in_ready);
        end
        compared++;
        if (bcd_out !== 8'h42) begin mismatched++; $display("FAIL bp_bcd_kept got=%h exp=42", bcd_out); end
    endtask

    task automatic test_small_values();
        int lat;
        out_ready = 1'b1;
        accept(8'b00_000000);
        wait_out(lat);
        compared++;
        if (lat !== 6 || bcd_out !== 8'h00) begin
            mismatched++; $display("FAIL zero lat=%0d bcd=%h exp=6/00", lat, bcd_out);
        end
        tick();
        accept(8'b11_001001);
        wait_out(lat);
        compared++;
        if (lat !== 6 || bcd_out !== 8'h09 || op_out !== 2'b11) begin
            mismatched++; $display("FAIL nine lat=%0d bcd=%h op=%b exp=6/09/11", lat, bcd_out, op_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        accept(8'b00_100101);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (in_ready !== 1'b1 || bcd_out !== 8'h00 || busy !== 1'b0) begin
            mismatched++; $display("FAIL midrst_state in_ready=%b bcd=%h busy=%b exp=1/00/0", in_ready, bcd_out, busy);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        compared++;
        if (seen !== 0) begin mismatched++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
    endtask

    task automatic test_signed();
        int lat;
        out_ready = 1'b1;
        accept(8'b01_111011);
        wait_out(lat);
`ifdef SIGNED_EN
        compared++;
        if (lat !== 6 || sign_out !== 1'b1 || bcd_out !== 8'h05) begin
            mismatched++; $display("FAIL signed lat=%0d sign=%b bcd=%h exp=6/1/05", lat, sign_out, bcd_out);
        end
`else
        compared++;
        if (lat !== 6 || sign_out !== 1'b0 || bcd_out !== 8'h59) begin
            mismatched++; $display("FAIL signed lat=%0d sign=%b bcd=%h exp=6/0/59", lat, sign_out, bcd_out);
        end
`endif
        compared++;
        if (op_out !== 2'b01) begin mismatched++; $display("FAIL signed_op got=%b exp=01", op_out); end
        tick();
    endtask

    // in_valid held high continuously: accepts are RES_W+2 = 8 edges apart.
    task automatic test_back_to_back();
        int lat;
        int lat2;
        out_ready = 1'b1;
        while (!in_ready) tick();
        in_data  = 8'b00_010011;
        in_valid = 1'b1;
        tick();
        wait_out(lat);
        compared++;
        if (lat !== 6 || bcd_out !== 8'h19) begin
            mismatched++; $display("FAIL b2b_first lat=%0d bcd=%h exp=6/19", lat, bcd_out);
        end
        in_data = 8'b10_100000;
        tick();
        wait_out(lat2);
        compared++;
        if (lat + 1 + lat2 !== 14) begin
            mismatched++; $display("FAIL b2b_spacing got=%0d exp=14", lat + 1 + lat2);
        end
        compared++;
        if (bcd_out !== 8'h32 || op_out !== 2'b10) begin
            mismatched++; $display("FAIL b2b_second bcd=%h op=%b exp=32/10", bcd_out, op_out);
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        test_reset();
        test_max_value();
        test_backpressure();
        test_small_values();
        test_reset_mid();
        test_signed();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
